// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD nibble of the double-dabble step: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // din is at most 9 here, so the 4-bit sum never wraps
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one shift per clock,
// result and DONE strobe registered together on the final shift.
module bcd_conv
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = bcd_pkg::WIDTH,
    parameter int unsigned DIGITS = bcd_pkg::DIGITS
) (
    input  logic                  CLOCK,
    input  logic                  RESET_B,
    input  logic                  START,
    input  logic [WIDTH-1:0]      BIN,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned SW = BW + WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sreg_q, sreg_d, sreg_adj;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;
    logic            last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sreg_q[WIDTH + 4*g +: 4]),
            .dout (sreg_adj[WIDTH + 4*g +: 4])
        );
    end
    assign sreg_adj[WIDTH-1:0] = sreg_q[WIDTH-1:0];

    assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge CLOCK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START)      state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // START during SHIFT is ignored: BIN is only loaded from IDLE
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (START) begin
                sreg_d = {{BW{1'b0}}, BIN};
                cnt_d  = '0;
            end
        end else begin
            sreg_d = {sreg_adj[SW-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
            if (last_shift) begin
                bcd_d  = sreg_adj[SW-2 -: BW];
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        BUSY = (state_q == SHIFT);
        DONE = done_q;
        BCD  = bcd_q;
    end

endmodule
